simon_enc_core: RTL and testbench

//  Iterative Simon block-encryption engine. Wraps one simon_round instance and sequences it for T rounds.

---
 rtl/simon_enc_core.sv | 147 ++++++++++++++
 tb/tb_simon_enc_core.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/simon_enc_core.sv
// Iterative Simon block cipher: one round per clock, round keys expanded on the fly
// from a sliding window of KW key words, valid/ready handshakes on both sides.

module simon_round #(
  parameter int WW = 16
) (
  input  logic [WW-1:0] x,
  input  logic [WW-1:0] y,
  input  logic [WW-1:0] k,
  output logic [WW-1:0] x_nxt,
  output logic [WW-1:0] y_nxt
);
  function automatic logic [WW-1:0] rotl(input logic [WW-1:0] v, input int s);
    return (v << s) | (v >> (WW - s));
  endfunction

  assign x_nxt = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ k;
  assign y_nxt = x;
endmodule

module simon_enc_core #(
  parameter int WW = 16,
  parameter int KW = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2*WW-1:0]   pt_i,
  input  logic [KW*WW-1:0]  key_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [2*WW-1:0]   ct_o,
  output logic              busy_o
);
  function automatic int sel_f(input int ww, input int kw, input bit want_j);
    int t, j;
    t = 0; j = -1;
    case ({ww[7:0], kw[3:0]})
      {8'd16, 4'd4}: begin t = 32; j = 0; end
      {8'd24, 4'd3}: begin t = 36; j = 0; end
      {8'd24, 4'd4}: begin t = 36; j = 1; end
      {8'd32, 4'd3}: begin t = 42; j = 2; end
      {8'd32, 4'd4}: begin t = 44; j = 3; end
      {8'd48, 4'd2}: begin t = 52; j = 2; end
      {8'd48, 4'd3}: begin t = 54; j = 3; end
      {8'd64, 4'd2}: begin t = 68; j = 2; end
      {8'd64, 4'd3}: begin t = 69; j = 3; end
      {8'd64, 4'd4}: begin t = 72; j = 4; end
      default:       begin t = 0;  j = -1; end
    endcase
    return want_j ? j : t;
  endfunction

  function automatic logic [WW-1:0] rotr(input logic [WW-1:0] v, input int s);
    return (v >> s) | (v << (WW - s));
  endfunction

  localparam bit LEGAL = (sel_f(WW, KW, 1'b0) != 0);
  localparam int T     = LEGAL ? sel_f(WW, KW, 1'b0) : 32;
  localparam int J     = LEGAL ? sel_f(WW, KW, 1'b1) : 0;
  localparam int CW    = $clog2(T);

  // Published z strings, leftmost character in bit 61 so z_J[i] = ZSEQ[61-i].
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000000100001011100001100101001001111101;
  localparam logic [61:0] ZSEQ = (J == 0) ? Z0 : (J == 1) ? Z1 : (J == 2) ? Z2 :
                                 (J == 3) ? Z3 : Z4;

  if (!LEGAL) begin : g_illegal
    $error("simon_enc_core: unsupported WW/KW pair %0d/%0d", WW, KW);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_p0, state_nxt;
  logic [WW-1:0]  x_p0, y_p0;
  logic [WW-1:0]  k_p0 [KW];
  logic [CW-1:0]  rnd_p0;
  logic [WW-1:0]  x_rnd, y_rnd, k_new, tmp;
  logic [5:0]     zpos;
  logic           accept, last;
  int             zi;

  simon_round #(.WW(WW)) u_round (
    .x     (x_p0),
    .y     (y_p0),
    .k     (k_p0[0]),
    .x_nxt (x_rnd),
    .y_nxt (y_rnd)
  );

  assign accept      = in_valid_i && (state_p0 == IDLE);
  assign last        = (rnd_p0 == CW'(T - 1));
  assign in_ready_o  = (state_p0 == IDLE);
  assign out_valid_o = (state_p0 == DONE);
  assign busy_o      = (state_p0 != IDLE);
  assign ct_o        = {x_p0, y_p0};

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Key word for round i+KW, built while round i consumes k_p0[0].
  always_comb begin
    tmp = rotr(k_p0[KW-1], 3);
    if (KW == 4) tmp = tmp ^ k_p0[1];
    tmp = tmp ^ rotr(tmp, 1);
    zi = int'(rnd_p0);
    if (zi >= 62) zi = zi - 62;
    zpos  = 6'(61 - zi);
    k_new = ~k_p0[0] ^ tmp ^ {{(WW-1){1'b0}}, ZSEQ[zpos]} ^ WW'(3);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_p0 <= IDLE;
      x_p0     <= '0;
      y_p0     <= '0;
      rnd_p0   <= '0;
      for (int j = 0; j < KW; j++) k_p0[j] <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (accept) begin
        x_p0   <= pt_i[2*WW-1:WW];
        y_p0   <= pt_i[WW-1:0];
        rnd_p0 <= '0;
        for (int j = 0; j < KW; j++) k_p0[j] <= key_i[j*WW +: WW];
      end else if (state_p0 == RUN) begin
        x_p0 <= x_rnd;
        y_p0 <= y_rnd;
        for (int j = 0; j < KW-1; j++) k_p0[j] <= k_p0[j+1];
        k_p0[KW-1] <= k_new;
        if (!last) rnd_p0 <= rnd_p0 + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_simon_enc_core.sv
// Directed-vector bench for simon_enc_core: Simon32/64 and Simon64/128 reference vectors,
// backpressure, back-to-back blocks, mid-run reset and input noise during a run.

module tb_simon_enc_core;
  localparam logic [63:0]  KEY16 = 64'h1918_1110_0908_0100;
  localparam logic [31:0]  PT16  = 32'h6565_6877;
  localparam logic [31:0]  CT16  = 32'hc69b_e9bb;
  localparam logic [127:0] KEY32 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT32  = 64'h656b696c_20646e75;
  localparam logic [63:0]  CT32  = 64'h44c8fc20_b9dfa07a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0, busy16;
  logic [31:0] pt16 = '0, ct16;
  logic [63:0] key16 = '0;

  logic         in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b0, busy32;
  logic [63:0]  pt32 = '0, ct32;
  logic [127:0] key32 = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  simon_enc_core #(.WW(16), .KW(4)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid16), .in_ready_o(in_ready16),
    .pt_i(pt16), .key_i(key16), .out_valid_o(out_valid16), .out_ready_i(out_ready16),
    .ct_o(ct16), .busy_o(busy16)
  );

  simon_enc_core #(.WW(32), .KW(4)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid32), .in_ready_o(in_ready32),
    .pt_i(pt32), .key_i(key32), .out_valid_o(out_valid32), .out_ready_i(out_ready32),
    .ct_o(ct32), .busy_o(busy32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run16(input string tag, input int hold, input bit noise);
    int lat;
    @(negedge clk);
    in_valid16 = 1'b1; pt16 = PT16; key16 = KEY16; out_ready16 = 1'b0;
    check({tag, "_rdy_idle"}, 64'(in_ready16), 64'd1);
    @(negedge clk);
    in_valid16 = 1'b0;
    check({tag, "_busy_run"}, 64'(busy16), 64'd1);
    check({tag, "_rdy_run"}, 64'(in_ready16), 64'd0);
    lat = 0;
    while (!out_valid16 && lat < 200) begin
      if (noise) begin
        in_valid16 = 1'($urandom_range(0, 1));
        pt16 = $urandom;
        key16 = {$urandom, $urandom};
      end
      @(negedge clk);
      lat++;
    end
    in_valid16 = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd32);
    check({tag, "_ct"}, 64'(ct16), 64'(CT16));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_vld"}, 64'(out_valid16), 64'd1);
      check({tag, "_hold_ct"}, 64'(ct16), 64'(CT16));
      check({tag, "_hold_rdy"}, 64'(in_ready16), 64'd0);
    end
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    check({tag, "_vld_drop"}, 64'(out_valid16), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready16), 64'd1);
    check({tag, "_busy_clr"}, 64'(busy16), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, acc1, acc2;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdy", 64'(in_ready16), 64'd1);
    check("rst_vld", 64'(out_valid16), 64'd0);
    check("rst_busy", 64'(busy16), 64'd0);
    check("rst_ct", 64'(ct16), 64'd0);
    check("rst_ct32", ct32, 64'd0);
    rst_n = 1'b1;

    // T1 Simon32/64
    run16("t1", 0, 1'b0);

    // T2 Simon64/128
    @(negedge clk);
    in_valid32 = 1'b1; pt32 = PT32; key32 = KEY32; out_ready32 = 1'b0;
    @(negedge clk);
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("t2_latency", 64'(lat), 64'd44);
    check("t2_ct", ct32, CT32);
    out_ready32 = 1'b1;
    @(negedge clk);
    out_ready32 = 1'b0;
    check("t2_rdy_back", 64'(in_ready32), 64'd1);

    // T3 backpressure
    run16("t3", 10, 1'b0);

    // T4 back-to-back with in_valid held
    @(negedge clk);
    in_valid16 = 1'b1; pt16 = PT16; key16 = KEY16; out_ready16 = 1'b1;
    @(negedge clk);
    acc1 = cyc;
    lat = 0;
    while (!out_valid16 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("t4_ct_a", 64'(ct16), 64'(CT16));
    lat = 0;
    while (!in_ready16 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    acc2 = cyc;
    in_valid16 = 1'b0;
    check("t4_interval", 64'(acc2 - acc1), 64'd34);
    lat = 0;
    while (!out_valid16 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("t4_latency_b", 64'(lat), 64'd32);
    check("t4_ct_b", 64'(ct16), 64'(CT16));
    @(negedge clk);
    out_ready16 = 1'b0;
    check("t4_rdy_end", 64'(in_ready16), 64'd1);

    // T5 reset during round 10
    @(negedge clk);
    in_valid16 = 1'b1; pt16 = PT16; key16 = KEY16;
    @(negedge clk);
    in_valid16 = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rdy", 64'(in_ready16), 64'd1);
    check("t5_rst_vld", 64'(out_valid16), 64'd0);
    check("t5_rst_busy", 64'(busy16), 64'd0);
    repeat (2) @(negedge clk);
    check("t5_rst_rdy_hold", 64'(in_ready16), 64'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid16) seen = 1'b1;
    end
    check("t5_no_output", 64'(seen), 64'd0);
    check("t5_idle_after", 64'(in_ready16), 64'd1);
    run16("t5_fresh", 0, 1'b0);

    // T6 input noise during the run
    run16("t6", 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
